// File: rtl/d5m_pkg.sv
// rtl/d5m_pkg.sv - shared state, default limits and pixel-beat type for the D5M capture front end
package d5m_pkg;
   localparam int D5M_DATA_W = 12;
   localparam int D5M_CNT_W  = 12;
   localparam int D5M_MAX_W  = 2592;
   localparam int D5M_MAX_H  = 1944;

   typedef enum logic [1:0] {SYNC, WAIT_FRAME, FRAME} cap_state_t;

   typedef struct packed {
      logic [D5M_DATA_W-1:0] data;
      logic                  sof;
      logic                  eol;
      logic [D5M_CNT_W-1:0]  x;
      logic [D5M_CNT_W-1:0]  y;
   } pix_beat_t;
endpackage

// File: rtl/d5m_geom_stats.sv
// rtl/d5m_geom_stats.sv - frame counter and per-frame line-length / overflow error accumulators
module d5m_geom_stats #(
   parameter int CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sof,
   input  logic             ovf,
   input  logic             line_end,
   input  logic             line_first,
   input  logic [CNT_W-1:0] line_len,
   input  logic [CNT_W-1:0] line0_len,
   input  logic             done,
   output logic [15:0]      frame_count,
   output logic             err_line_len,
   output logic             err_overflow
);
   logic acc_len;
   logic acc_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_len      <= 1'b0;
         acc_ovf      <= 1'b0;
         frame_count  <= 16'd0;
         err_line_len <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         if (sof) begin
            acc_len <= 1'b0;
            acc_ovf <= 1'b0;
         end else begin
            if (ovf)
               acc_ovf <= 1'b1;
            if (line_end && !line_first && (line_len != line0_len))
               acc_len <= 1'b1;
         end
         if (done) begin
            frame_count  <= frame_count + 16'd1;
            err_line_len <= acc_len;
            err_overflow <= acc_ovf;
         end
      end
   end
endmodule

// File: rtl/d5m_frame_capture.sv
// rtl/d5m_frame_capture.sv - D5M pin capture: qualified pixel stream with SOF/EOL, x/y and frame geometry
// Optional statistics (frame_count, err_line_len, err_overflow) enabled by D5M_CAPTURE_STATS_EN.
module d5m_frame_capture
   import d5m_pkg::*;
#(
   parameter int DATA_W = D5M_DATA_W,
   parameter int MAX_W  = D5M_MAX_W,
   parameter int MAX_H  = D5M_MAX_H,
   parameter int CNT_W  = D5M_CNT_W
) (
   input  logic              pixclk,
   input  logic              ARESETN,
   input  logic [DATA_W-1:0] idata,
   input  logic              ifval,
   input  logic              ilval,
   output logic              pix_valid,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_sof,
   output logic              pix_eol,
   output logic [CNT_W-1:0]  pix_x,
   output logic [CNT_W-1:0]  pix_y,
   output logic              frame_done,
   output logic [CNT_W-1:0]  frame_width,
   output logic [CNT_W-1:0]  frame_height,
   output logic [15:0]       frame_count,
   output logic              err_line_len,
   output logic              err_overflow
);
   logic [DATA_W-1:0] s1_data, s2_data;
   logic              s1_fval, s1_lval, s2_fval, s2_lval, s1_ok;
   logic              s1_pix, s2_pix;
   cap_state_t        state, state_nx;
   logic [CNT_W-1:0]  x_cnt, y_cnt, line0_len;
   logic              sof_pend, fall, fall_q;
   logic              take, accept, line_end, eol_nx, x_ovf, y_ovf;
   pix_beat_t         beat;
   logic              beat_valid;

   assign s1_pix = s1_fval && s1_lval;
   assign s2_pix = s2_fval && s2_lval;
   assign x_ovf  = (x_cnt >= CNT_W'(MAX_W));
   assign y_ovf  = (y_cnt >= CNT_W'(MAX_H));

   // s1_ok keeps SYNC from trusting the reset value of s1 before a real sample lands
   always_ff @(posedge pixclk or negedge ARESETN) begin
      if (!ARESETN)
         state <= SYNC;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      fall     = 1'b0;
      take     = 1'b0;
      accept   = 1'b0;
      line_end = 1'b0;
      eol_nx   = 1'b0;
      case (state)
         SYNC:       if (s1_ok && !s1_fval) state_nx = WAIT_FRAME;
         WAIT_FRAME: if (s1_fval) state_nx = FRAME;
         FRAME: begin
            take     = s2_pix;
            line_end = s2_pix && !s1_pix;
            accept   = s2_pix && !x_ovf && !y_ovf;
            // an over-wide line ends its visible part at the last accepted column
            eol_nx   = accept && (!s1_pix || (x_cnt == CNT_W'(MAX_W - 1)));
            if (!s1_fval) begin
               state_nx = WAIT_FRAME;
               fall     = 1'b1;
            end
         end
         default:    state_nx = SYNC;
      endcase
   end

   always_ff @(posedge pixclk or negedge ARESETN) begin
      if (!ARESETN) begin
         s1_data      <= '0;
         s2_data      <= '0;
         s1_fval      <= 1'b0;
         s1_lval      <= 1'b0;
         s2_fval      <= 1'b0;
         s2_lval      <= 1'b0;
         s1_ok        <= 1'b0;
         x_cnt        <= '0;
         y_cnt        <= '0;
         line0_len    <= '0;
         sof_pend     <= 1'b0;
         fall_q       <= 1'b0;
         frame_done   <= 1'b0;
         frame_width  <= '0;
         frame_height <= '0;
         beat         <= '0;
         beat_valid   <= 1'b0;
      end else begin
         s1_ok      <= 1'b1;
         s1_data    <= idata;
         s1_fval    <= ifval;
         s1_lval    <= ilval;
         s2_data    <= s1_data;
         s2_fval    <= s1_fval;
         s2_lval    <= s1_lval;
         fall_q     <= fall;
         frame_done <= fall_q;
         beat_valid <= accept;
         beat.sof   <= accept && sof_pend;
         beat.eol   <= eol_nx;
         if (accept) begin
            beat.data <= D5M_DATA_W'(s2_data);
            beat.x    <= D5M_CNT_W'(x_cnt);
            beat.y    <= D5M_CNT_W'(y_cnt);
         end
         // x keeps counting past MAX_W so the reported geometry is what the sensor sent
         if (state == WAIT_FRAME) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            line0_len <= '0;
            sof_pend  <= 1'b1;
         end else if (take) begin
            if (accept)
               sof_pend <= 1'b0;
            if (line_end) begin
               x_cnt <= '0;
               y_cnt <= y_cnt + CNT_W'(1);
               if (y_cnt == '0)
                  line0_len <= x_cnt + CNT_W'(1);
            end else begin
               x_cnt <= x_cnt + CNT_W'(1);
            end
         end
         if (fall_q) begin
            frame_width  <= line0_len;
            frame_height <= y_cnt;
         end
      end
   end

   assign pix_valid = beat_valid;
   assign pix_data  = DATA_W'(beat.data);
   assign pix_sof   = beat.sof;
   assign pix_eol   = beat.eol;
   assign pix_x     = CNT_W'(beat.x);
   assign pix_y     = CNT_W'(beat.y);

`ifdef D5M_CAPTURE_STATS_EN
   d5m_geom_stats #(.CNT_W(CNT_W)) u_stats (
      .clk         (pixclk),
      .rst_n       (ARESETN),
      .sof         (accept && sof_pend),
      .ovf         (take && !accept),
      .line_end    (line_end),
      .line_first  (y_cnt == '0),
      .line_len    (x_cnt + CNT_W'(1)),
      .line0_len   (line0_len),
      .done        (fall_q),
      .frame_count (frame_count),
      .err_line_len(err_line_len),
      .err_overflow(err_overflow)
   );
`else
   assign frame_count  = 16'd0;
   assign err_line_len = 1'b0;
   assign err_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_d5m_frame_capture.sv
// tb/tb_d5m_frame_capture.sv - table-driven scoreboard bench for d5m_frame_capture
module tb_d5m_frame_capture;
   localparam int DW = 12;
   localparam int MW = 8;
   localparam int MH = 4;
   localparam int CW = 12;

   logic          pixclk = 1'b0;
   logic          ARESETN = 1'b0;
   logic [DW-1:0] idata = '0;
   logic          ifval = 1'b0;
   logic          ilval = 1'b0;
   logic          pix_valid, pix_sof, pix_eol, frame_done, err_line_len, err_overflow;
   logic [DW-1:0] pix_data;
   logic [CW-1:0] pix_x, pix_y, frame_width, frame_height;
   logic [15:0]   frame_count;

   d5m_frame_capture #(.DATA_W(DW), .MAX_W(MW), .MAX_H(MH), .CNT_W(CW)) dut (
      .pixclk(pixclk), .ARESETN(ARESETN), .idata(idata), .ifval(ifval), .ilval(ilval),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol),
      .pix_x(pix_x), .pix_y(pix_y), .frame_done(frame_done), .frame_width(frame_width),
      .frame_height(frame_height), .frame_count(frame_count), .err_line_len(err_line_len),
      .err_overflow(err_overflow)
   );

   always #5 pixclk = ~pixclk;

   typedef struct {
      int nl;      // lines
      int w;       // pixels per line
      int sl;      // index of the odd-length line, -1 for none
      int slw;     // its length
      bit cut;     // ifval falls while ilval is still high on the last line
      int ew;
      int eh;
      bit elen;
      bit eovf;
   } frame_t;

   frame_t      tbl[8];
   logic [55:0] exp_q[$];
   int          n_pass = 0;
   int          n_total = 0;
   int          cyc = 0;
   int          exp_done = -1;
   int          done_cnt = 0;
   int          ew = 0, eh = 0, ecnt = 0;
   bit          elen = 0, eovf = 0;

   function automatic logic [55:0] pk(input logic [11:0] d, input logic s, input logic e,
                                      input logic [11:0] x, input logic [11:0] y, input int c);
      logic [31:0] cv;
      cv = c;
      return {d, s, e, x, y, cv[17:0]};
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", nm, got, exp, cyc);
   endtask

   task automatic tick();
      logic [55:0] e;
      @(negedge pixclk);
      cyc++;
      if (pix_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pix", 64'(pix_valid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("pix_beat", 64'(pk(pix_data, pix_sof, pix_eol, pix_x, pix_y, cyc)), 64'(e));
         end
      end
      if (frame_done) begin
         done_cnt++;
         chk("done_time", 64'(cyc), 64'(exp_done));
         chk("frame_width", 64'(frame_width), 64'(ew));
         chk("frame_height", 64'(frame_height), 64'(eh));
         chk("frame_count", 64'(frame_count), 64'(ecnt));
         chk("err_line_len", 64'(err_line_len), 64'(elen));
         chk("err_overflow", 64'(err_overflow), 64'(eovf));
      end
   endtask

   task automatic run_frame(input frame_t f, input int idx);
      int wl;
      bit first;
      first = 1'b1;
      ew = f.ew;
      eh = f.eh;
`ifdef D5M_CAPTURE_STATS_EN
      ecnt = idx + 1;
      elen = f.elen;
      eovf = f.eovf;
`else
      ecnt = 0;
      elen = 1'b0;
      eovf = 1'b0;
`endif
      ifval = 1'b1;
      ilval = 1'b0;
      tick();
      tick();
      for (int l = 0; l < f.nl; l++) begin
         wl = (l == f.sl) ? f.slw : f.w;
         for (int x = 0; x < wl; x++) begin
            ilval = 1'b1;
            idata = 12'(32'h100 + l * 16 + x);
            if (x < MW && l < MH) begin
               exp_q.push_back(pk(idata, first, (x == wl - 1) || (x == MW - 1),
                                  12'(x), 12'(l), cyc + 3));
               first = 1'b0;
            end
            tick();
         end
         if (f.cut && l == f.nl - 1) begin
            ifval = 1'b0;
            ilval = 1'b1;
         end else begin
            ilval = 1'b0;
            tick();
         end
      end
      ifval = 1'b0;
      exp_done = cyc + 3;
      tick();
      // line-valid pulses outside a frame must be ignored
      ilval = 1'b1;
      idata = 12'hABC;
      tick();
      tick();
      ilval = 1'b0;
      repeat (5) tick();
      chk("stream_drained", 64'(exp_q.size()), 64'd0);
      chk("done_pulses", 64'(done_cnt), 64'd1);
      chk("width_hold", 64'(frame_width), 64'(ew));
      done_cnt = 0;
      exp_done = -1;
      exp_q.delete();
   endtask

   initial begin
      tbl[0] = '{4, 8, -1, 0, 1'b0, 8, 4, 1'b0, 1'b0};
      tbl[1] = '{4, 8, 2, 6, 1'b0, 8, 4, 1'b1, 1'b0};
      tbl[2] = '{4, 8, -1, 0, 1'b0, 8, 4, 1'b0, 1'b0};
      tbl[3] = '{2, 10, -1, 0, 1'b0, 10, 2, 1'b0, 1'b1};
      tbl[4] = '{1, 1, -1, 0, 1'b0, 1, 1, 1'b0, 1'b0};
      tbl[5] = '{3, 5, -1, 0, 1'b1, 5, 3, 1'b0, 1'b0};
      tbl[6] = '{5, 3, -1, 0, 1'b0, 3, 5, 1'b0, 1'b1};
      tbl[7] = '{4, 8, -1, 0, 1'b0, 8, 4, 1'b0, 1'b0};

      // reset held while the sensor is mid-frame
      ARESETN = 1'b0;
      ifval = 1'b1;
      ilval = 1'b1;
      repeat (3) begin
         idata = 12'($urandom);
         tick();
      end
      chk("reset_outputs", {pix_valid, pix_data, pix_sof, pix_eol, pix_x, pix_y,
                            frame_done, frame_width, frame_height}, 64'd0);
      chk("reset_stats", {45'd0, frame_count, err_line_len, err_overflow}, 64'd0);
      ARESETN = 1'b1;

      // tail of the interrupted frame: must produce neither pixels nor frame_done
      repeat (2) begin
         ilval = 1'b1;
         repeat (4) begin
            idata = 12'($urandom);
            tick();
         end
         ilval = 1'b0;
         tick();
      end
      ifval = 1'b0;
      repeat (4) tick();

      for (int i = 0; i < 8; i++)
         run_frame(tbl[i], i);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
